// File: rtl/simple_switch.sv
`default_nettype none
// ============================================================================
//  Module   : simple_switch
//  Purpose  : NumRx x NumTx crossbar packet switch, one data word per transfer.
//             Each input word carries a destination index and is routed to
//             that output. Each output has a one-entry registered buffer and
//             its own round-robin arbiter.
//  Ports    : clk, rst            - clock, synchronous active-high reset
//             rx_valid_i/rx_dest_i/rx_data_i/rx_ready_o - per-input handshake
//             tx_valid_o/tx_data_o/tx_src_o/tx_ready_i  - per-output handshake
//             tx_count_o, drop_count_o - statistics (SIMPLE_SWITCH_STATS_EN)
//  Options  : SIMPLE_SWITCH_STATS_EN adds delivered/discard counters.
//  Revision : 1.0 - initial release
// ============================================================================
module simple_switch #(
  parameter  int NumRx     = 4,
  parameter  int NumTx     = 4,
  parameter  int DataWidth = 8,
  localparam int DestW     = (NumTx > 1) ? $clog2(NumTx) : 1,
  localparam int SrcW      = (NumRx > 1) ? $clog2(NumRx) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NumRx-1:0]           rx_valid_i,
  input  logic [NumRx*DestW-1:0]     rx_dest_i,
  input  logic [NumRx*DataWidth-1:0] rx_data_i,
  output logic [NumRx-1:0]           rx_ready_o,
  output logic [NumTx-1:0]           tx_valid_o,
  output logic [NumTx*DataWidth-1:0] tx_data_o,
  output logic [NumTx*SrcW-1:0]      tx_src_o,
  input  logic [NumTx-1:0]           tx_ready_i
`ifdef SIMPLE_SWITCH_STATS_EN
  ,
  output logic [NumTx*16-1:0]        tx_count_o,
  output logic [15:0]                drop_count_o
`endif
);

  logic [NumTx-1:0]           tx_valid_q;
  logic [NumTx*DataWidth-1:0] tx_data_q;
  logic [NumTx*SrcW-1:0]      tx_src_q;
  logic [SrcW-1:0]            rr_q [NumTx];
  logic [SrcW-1:0]            rr_d [NumTx];

  logic [NumTx-1:0]           w_load_ok;
  logic [NumRx-1:0]           w_invalid;
  logic [NumRx-1:0]           w_req [NumTx];
  logic [NumTx-1:0]           w_gnt_vld;
  logic [SrcW-1:0]            w_gnt_idx [NumTx];
  logic [NumRx-1:0]           w_rx_ready;

  // Wrap an offset pointer value back into 0..NumRx-1 (v < 2*NumRx).
  function automatic logic [SrcW-1:0] f_wrap(input int v);
    return (v >= NumRx) ? SrcW'(v - NumRx) : SrcW'(v);
  endfunction

  // Out-of-range destinations can only exist when NumTx is not a power of 2.
  generate
    if ((1 << DestW) != NumTx) begin : g_dest_check
      always_comb begin
        w_invalid = '0;
        for (int i = 0; i < NumRx; i++) begin
          w_invalid[i] = rx_valid_i[i] && (rx_dest_i[i*DestW +: DestW] >= DestW'(NumTx));
        end
      end
    end else begin : g_dest_pow2
      assign w_invalid = '0;
    end
  endgenerate

  always_comb begin
    for (int j = 0; j < NumTx; j++) begin
      // An output may take a new word when empty or draining this cycle.
      w_load_ok[j] = !tx_valid_q[j] || tx_ready_i[j];
      w_req[j]     = '0;
      for (int i = 0; i < NumRx; i++) begin
        w_req[j][i] = rx_valid_i[i] && (rx_dest_i[i*DestW +: DestW] == DestW'(j));
      end
    end
  end

  // Per-output round-robin: scan from rr_q[j]; first requester wins.
  always_comb begin
    for (int j = 0; j < NumTx; j++) begin
      w_gnt_vld[j] = 1'b0;
      w_gnt_idx[j] = '0;
      for (int k = 0; k < NumRx; k++) begin
        if (!w_gnt_vld[j] && w_load_ok[j] && w_req[j][f_wrap(int'(rr_q[j]) + k)]) begin
          w_gnt_vld[j] = 1'b1;
          w_gnt_idx[j] = f_wrap(int'(rr_q[j]) + k);
        end
      end
      rr_d[j] = w_gnt_vld[j] ? f_wrap(int'(w_gnt_idx[j]) + 1) : rr_q[j];
    end
  end

  // Invalid destinations are accepted and dropped at once.
  always_comb begin
    w_rx_ready = w_invalid;
    for (int j = 0; j < NumTx; j++) begin
      if (w_gnt_vld[j]) begin
        w_rx_ready[w_gnt_idx[j]] = 1'b1;
      end
    end
    if (rst) begin
      w_rx_ready = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_valid_q <= '0;
      tx_data_q  <= '0;
      tx_src_q   <= '0;
      for (int j = 0; j < NumTx; j++) begin
        rr_q[j] <= '0;
      end
    end else begin
      for (int j = 0; j < NumTx; j++) begin
        rr_q[j] <= rr_d[j];
        if (w_gnt_vld[j]) begin
          tx_valid_q[j]                         <= 1'b1;
          tx_data_q[j*DataWidth +: DataWidth]   <= rx_data_i[int'(w_gnt_idx[j])*DataWidth +: DataWidth];
          tx_src_q[j*SrcW +: SrcW]              <= w_gnt_idx[j];
        end else if (tx_ready_i[j]) begin
          tx_valid_q[j] <= 1'b0;
        end
      end
    end
  end

  assign rx_ready_o = w_rx_ready;
  assign tx_valid_o = tx_valid_q;
  assign tx_data_o  = tx_data_q;
  assign tx_src_o   = tx_src_q;

`ifdef SIMPLE_SWITCH_STATS_EN
  logic [NumTx*16-1:0] tx_count_q;
  logic [15:0]         drop_count_q;
  logic [15:0]         w_drop_inc;

  always_comb begin
    w_drop_inc = '0;
    for (int i = 0; i < NumRx; i++) begin
      w_drop_inc = w_drop_inc + {15'b0, w_invalid[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_count_q   <= '0;
      drop_count_q <= '0;
    end else begin
      for (int j = 0; j < NumTx; j++) begin
        if (tx_valid_q[j] && tx_ready_i[j]) begin
          tx_count_q[j*16 +: 16] <= tx_count_q[j*16 +: 16] + 16'd1;
        end
      end
      drop_count_q <= drop_count_q + w_drop_inc;
    end
  end

  assign tx_count_o   = tx_count_q;
  assign drop_count_o = drop_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_simple_switch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_simple_switch
//  Purpose  : Self-checking bench for simple_switch (4x4, 8-bit payload).
//             Directed scenarios plus random traffic compared against a
//             behavioural model of the switching rules.
//  Options  : SIMPLE_SWITCH_STATS_EN enables counter checks.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_simple_switch;
  localparam int NR = 4, NT = 4, DW = 8, DESTW = 2, SRCW = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     rx_valid;
  logic [NR*DESTW-1:0] rx_dest;
  logic [NR*DW-1:0]  rx_data;
  logic [NR-1:0]     rx_ready;
  logic [NT-1:0]     tx_valid;
  logic [NT*DW-1:0]  tx_data;
  logic [NT*SRCW-1:0] tx_src;
  logic [NT-1:0]     tx_ready;
`ifdef SIMPLE_SWITCH_STATS_EN
  logic [NT*16-1:0]  tx_count;
  logic [15:0]       drop_count;
`endif

  always #5 clk = ~clk;

  simple_switch #(.NumRx(NR), .NumTx(NT), .DataWidth(DW)) dut (
    .clk(clk), .rst(rst),
    .rx_valid_i(rx_valid), .rx_dest_i(rx_dest), .rx_data_i(rx_data), .rx_ready_o(rx_ready),
    .tx_valid_o(tx_valid), .tx_data_o(tx_data), .tx_src_o(tx_src), .tx_ready_i(tx_ready)
`ifdef SIMPLE_SWITCH_STATS_EN
    , .tx_count_o(tx_count), .drop_count_o(drop_count)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  bit            m_valid [NT];
  logic [DW-1:0] m_data  [NT];
  int            m_src   [NT];
  int            m_rr    [NT];
  bit            m_gv    [NT];
  int            m_gs    [NT];
  logic [NR-1:0] m_ready;
  int            m_cnt   [NT];

  // Winner of output j = requester with the smallest round-robin distance from rr[j].
  task automatic model_arbitrate();
    m_ready = '0;
    for (int j = 0; j < NT; j++) begin
      int best;
      best = NR;
      m_gv[j] = 1'b0;
      m_gs[j] = 0;
      if (!m_valid[j] || tx_ready[j]) begin
        for (int i = 0; i < NR; i++) begin
          if (rx_valid[i] && int'(rx_dest[i*DESTW +: DESTW]) == j) begin
            int d;
            d = (i - m_rr[j] + NR) % NR;
            if (d < best) begin
              best = d;
              m_gs[j] = i;
            end
          end
        end
        if (best < NR) begin
          m_gv[j] = 1'b1;
          m_ready[m_gs[j]] = 1'b1;
        end
      end
    end
    if (rst) m_ready = '0;
  endtask

  task automatic model_commit();
    for (int j = 0; j < NT; j++) begin
      if (rst) begin
        m_valid[j] = 1'b0; m_data[j] = '0; m_src[j] = 0; m_rr[j] = 0; m_cnt[j] = 0;
      end else begin
        if (m_valid[j] && tx_ready[j]) m_cnt[j] = (m_cnt[j] + 1) % 65536;
        if (m_gv[j]) begin
          m_valid[j] = 1'b1;
          m_data[j]  = rx_data[m_gs[j]*DW +: DW];
          m_src[j]   = m_gs[j];
          m_rr[j]    = (m_gs[j] + 1) % NR;
        end else if (tx_ready[j]) begin
          m_valid[j] = 1'b0;
        end
      end
    end
  endtask

  // One clock: model follows the DUT edge, then settle 1ns past the edge.
  task automatic tick();
    model_arbitrate();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  function automatic logic [NT-1:0] f_exp_valid();
    logic [NT-1:0] r;
    for (int j = 0; j < NT; j++) r[j] = m_valid[j];
    return r;
  endfunction

  function automatic logic [NT*DW-1:0] f_exp_data();
    logic [NT*DW-1:0] r;
    for (int j = 0; j < NT; j++) r[j*DW +: DW] = m_data[j];
    return r;
  endfunction

  function automatic logic [NT*SRCW-1:0] f_exp_src();
    logic [NT*SRCW-1:0] r;
    for (int j = 0; j < NT; j++) r[j*SRCW +: SRCW] = SRCW'(m_src[j]);
    return r;
  endfunction

  task automatic test_reset();
    rst = 1'b1; rx_valid = '1; rx_dest = 8'hE4; rx_data = 32'h1234_5678; tx_ready = '0;
    tick();
    n_checks++;
    if (tx_valid !== 4'b0000 || tx_data !== '0 || tx_src !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: valid=%b data=%h src=%h, want 0/0/0", tx_valid, tx_data, tx_src);
    end
    n_checks++;
    if (rx_ready !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_rx_ready: got %b want 0000", rx_ready);
    end
    rst = 1'b0; rx_valid = '0; tx_ready = '1;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_checks++;
      if (tx_valid !== 4'b0000 || rx_ready !== 4'b0000) begin
        n_fail++;
        $display("FAIL idle_after_reset: valid=%b rx_ready=%b want 0000/0000", tx_valid, rx_ready);
      end
    end
  endtask

  task automatic test_single_route();
    rx_valid = 4'b0001; rx_dest[1:0] = 2'd2; rx_data[7:0] = 8'hA5; tx_ready = '1;
    #1;
    model_arbitrate();
    n_checks++;
    if (rx_ready !== 4'b0001 || rx_ready !== m_ready) begin
      n_fail++;
      $display("FAIL single_rx_ready: got %b want 0001 (model %b)", rx_ready, m_ready);
    end
    tick();
    rx_valid = '0;
    n_checks++;
    if (tx_valid[2] !== 1'b1 || tx_data[2*DW +: DW] !== 8'hA5 || tx_src[2*SRCW +: SRCW] !== 2'd0) begin
      n_fail++;
      $display("FAIL single_out2: valid=%b data=%h src=%0d want 1/a5/0",
               tx_valid[2], tx_data[2*DW +: DW], tx_src[2*SRCW +: SRCW]);
    end
    n_checks++;
    if (tx_valid !== f_exp_valid()) begin
      n_fail++;
      $display("FAIL single_valid_vec: got %b want %b", tx_valid, f_exp_valid());
    end
    tick();
    n_checks++;
    if (tx_valid !== 4'b0000) begin
      n_fail++;
      $display("FAIL single_drain: got %b want 0000", tx_valid);
    end
  endtask

  task automatic test_contention();
    logic [NR-1:0] pending;
    logic [DW-1:0] seen[$];
    pending = '1;
    tx_ready = '1;
    for (int i = 0; i < NR; i++) begin
      rx_dest[i*DESTW +: DESTW] = 2'd1;
      rx_data[i*DW +: DW]       = DW'(8'h10 + i);
    end
    for (int c = 0; c < 8; c++) begin
      rx_valid = pending;
      #1;
      model_arbitrate();
      n_checks++;
      if (rx_ready !== m_ready) begin
        n_fail++;
        $display("FAIL contention_rx_ready c%0d: got %b want %b", c, rx_ready, m_ready);
      end
      tick();
      pending = pending & ~m_ready;
      n_checks++;
      if (tx_valid !== f_exp_valid() || tx_data !== f_exp_data() || tx_src !== f_exp_src()) begin
        n_fail++;
        $display("FAIL contention_out c%0d: valid=%b data=%h src=%h want %b/%h/%h",
                 c, tx_valid, tx_data, tx_src, f_exp_valid(), f_exp_data(), f_exp_src());
      end
      if (tx_valid[1] === 1'b1) seen.push_back(tx_data[1*DW +: DW]);
    end
    rx_valid = '0;
    n_checks++;
    if (seen.size() != 4 || seen[0] !== 8'h10 || seen[1] !== 8'h11 || seen[2] !== 8'h12 || seen[3] !== 8'h13) begin
      n_fail++;
      $display("FAIL contention_order: got %0d words %p want 10,11,12,13", seen.size(), seen);
    end
  endtask

  task automatic test_backpressure();
    tx_ready = 4'b0111;
    rx_valid = 4'b0001; rx_dest[1:0] = 2'd3; rx_data[7:0] = 8'h33;
    tick();
    rx_valid = 4'b0010; rx_dest[3:2] = 2'd3; rx_data[15:8] = 8'h44;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_checks++;
      if (rx_ready[1] !== 1'b0 || tx_valid[3] !== 1'b1 || tx_data[3*DW +: DW] !== 8'h33) begin
        n_fail++;
        $display("FAIL backpressure_hold c%0d: rx_ready1=%b valid3=%b data3=%h want 0/1/33",
                 c, rx_ready[1], tx_valid[3], tx_data[3*DW +: DW]);
      end
      tick();
    end
    tx_ready = '1;
    #1;
    model_arbitrate();
    n_checks++;
    if (rx_ready !== 4'b0010 || rx_ready !== m_ready) begin
      n_fail++;
      $display("FAIL backpressure_release: rx_ready=%b want 0010", rx_ready);
    end
    tick();
    rx_valid = '0;
    n_checks++;
    if (tx_valid[3] !== 1'b1 || tx_data[3*DW +: DW] !== 8'h44 || tx_src[3*SRCW +: SRCW] !== 2'd1) begin
      n_fail++;
      $display("FAIL backpressure_resume: valid3=%b data3=%h src3=%0d want 1/44/1",
               tx_valid[3], tx_data[3*DW +: DW], tx_src[3*SRCW +: SRCW]);
    end
    tick();
    n_checks++;
    if (tx_valid !== 4'b0000) begin
      n_fail++;
      $display("FAIL backpressure_no_dup: valid=%b want 0000", tx_valid);
    end
  endtask

  task automatic test_permutation();
    tx_ready = '1;
    rx_valid = '1;
    for (int i = 0; i < NR; i++) begin
      rx_dest[i*DESTW +: DESTW] = DESTW'(3 - i);
      rx_data[i*DW +: DW]       = DW'($urandom);
    end
    #1;
    n_checks++;
    if (rx_ready !== 4'b1111) begin
      n_fail++;
      $display("FAIL perm_rx_ready: got %b want 1111", rx_ready);
    end
    tick();
    rx_valid = '0;
    n_checks++;
    if (tx_valid !== 4'b1111 || tx_src !== 8'b00_01_10_11 || tx_data !== f_exp_data()) begin
      n_fail++;
      $display("FAIL perm_out: valid=%b src=%b data=%h want 1111/00011011/%h",
               tx_valid, tx_src, tx_data, f_exp_data());
    end
    tick();
  endtask

  task automatic test_random();
    logic [NR-1:0] acc;
    acc = '1;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NR; i++) begin
        if (!rx_valid[i] || acc[i]) begin
          if ($urandom_range(0, 3) != 0) begin
            rx_valid[i] = 1'b1;
            rx_dest[i*DESTW +: DESTW] = DESTW'($urandom_range(0, NT - 1));
            rx_data[i*DW +: DW]       = DW'($urandom);
          end else begin
            rx_valid[i] = 1'b0;
          end
        end
      end
      tx_ready = NT'($urandom_range(0, 15));
      #1;
      model_arbitrate();
      n_checks++;
      if (rx_ready !== m_ready) begin
        n_fail++;
        $display("FAIL random_rx_ready c%0d: got %b want %b", c, rx_ready, m_ready);
      end
      tick();
      acc = m_ready;
      n_checks++;
      if (tx_valid !== f_exp_valid() || tx_data !== f_exp_data() || tx_src !== f_exp_src()) begin
        n_fail++;
        $display("FAIL random_out c%0d: valid=%b data=%h src=%h want %b/%h/%h",
                 c, tx_valid, tx_data, tx_src, f_exp_valid(), f_exp_data(), f_exp_src());
      end
`ifdef SIMPLE_SWITCH_STATS_EN
      for (int j = 0; j < NT; j++) begin
        n_checks++;
        if (tx_count[j*16 +: 16] !== 16'(m_cnt[j])) begin
          n_fail++;
          $display("FAIL random_count%0d c%0d: got %0d want %0d", j, c, tx_count[j*16 +: 16], m_cnt[j]);
        end
      end
`endif
    end
    rx_valid = '0;
    tx_ready = '1;
    tick();
    tick();
  endtask

`ifdef SIMPLE_SWITCH_STATS_EN
  task automatic test_stats();
    rst = 1'b1; rx_valid = '0; tx_ready = '1;
    tick();
    rst = 1'b0;
    n_checks++;
    if (tx_count !== '0 || drop_count !== 16'd0) begin
      n_fail++;
      $display("FAIL stats_reset: tx_count=%h drop=%0d want 0/0", tx_count, drop_count);
    end
    rx_valid = 4'b0001; rx_dest[1:0] = 2'd0;
    for (int c = 0; c < 11; c++) begin
      rx_data[7:0] = DW'(c);
      tick();
    end
    n_checks++;
    if (tx_count[15:0] !== 16'd10 || tx_count[15:0] !== 16'(m_cnt[0])) begin
      n_fail++;
      $display("FAIL stats_count10: got %0d want 10", tx_count[15:0]);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0; rx_valid = '0;
    n_checks++;
    if (tx_count !== '0 || drop_count !== 16'd0 || tx_valid !== 4'b0000) begin
      n_fail++;
      $display("FAIL stats_midreset: tx_count=%h drop=%0d valid=%b want 0/0/0000", tx_count, drop_count, tx_valid);
    end
  endtask
`endif

  initial begin
    rst = 1'b1; rx_valid = '0; rx_dest = '0; rx_data = '0; tx_ready = '0;
    test_reset();
    test_single_route();
    test_contention();
    test_backpressure();
    test_permutation();
    test_random();
`ifdef SIMPLE_SWITCH_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
